// File: rtl/l2_cache_ctrl.sv
// l2_cache_ctrl: direct-mapped unified L2 shared by the instruction and data ports.
// A read miss fills the whole line as a word burst. Writes go through to memory with byte enables and do not allocate.
module l2_cache_ctrl #(
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned LINE_W  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        ins_req,
  input  logic [31:0] ins_addr,
  output logic [31:0] ins_rdata,
  output logic        ins_ready,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int unsigned NLINES = 1 << INDEX_W;
  localparam int unsigned NWORDS = 1 << (INDEX_W + LINE_W);
  localparam int unsigned WA_W   = INDEX_W + LINE_W;
  localparam int unsigned TAG_W  = 32 - WA_W - 2;
  localparam int unsigned K_W    = (LINE_W == 0) ? 1 : LINE_W;
  localparam logic [31:0]    LINE_MASK = 32'((1 << (LINE_W + 2)) - 1);
  localparam logic [K_W-1:0] K_LAST    = K_W'((1 << LINE_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_FILL, S_WRITE, S_RESP} state_t;
  typedef enum logic [1:0] {OP_INS, OP_DRD, OP_DWR} op_t;

  state_t r_state, w_next;
  op_t    r_op;
  logic [31:0]      r_addr, r_wdata;
  logic [3:0]       r_be;
  logic [K_W-1:0]   r_k;
  logic [NLINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [NLINES];
  logic [31:0]      r_data [NWORDS];

  logic        r_ins_ready, r_d_ready, r_mem_rd, r_mem_wr;
  logic [31:0] r_ins_rdata, r_d_rdata, r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;

  logic               w_any, w_hit, w_last;
  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [WA_W-1:0]    w_req_wa, w_fill_wa;
  logic [31:0]        w_fill_addr, w_cached, w_merged, w_rdata, w_mem_addr, w_mem_wdata;
  logic               w_ins_ready, w_d_ready, w_mem_rd, w_mem_wr;
  logic [3:0]         w_mem_be;

  assign w_any       = d_wr | d_rd | ins_req;
  assign w_index     = INDEX_W'(r_addr >> (LINE_W + 2));
  assign w_tag       = TAG_W'(r_addr >> (WA_W + 2));
  assign w_req_wa    = WA_W'(r_addr >> 2);
  assign w_fill_addr = (r_addr & ~LINE_MASK) | (32'(r_k) << 2);
  assign w_fill_wa   = WA_W'(w_fill_addr >> 2);
  assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_last      = (r_k == K_LAST);
  assign w_cached    = r_data[w_req_wa];

  always_comb begin
    w_merged = w_cached;
    for (int b = 0; b < 4; b++) begin
      if (r_be[b]) w_merged[8*b +: 8] = r_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!flush && w_any) w_next = S_LOOKUP;
      S_LOOKUP: begin
        if (r_op == OP_DWR) w_next = S_WRITE;
        else if (w_hit)     w_next = S_RESP;
        else                w_next = S_FILL;
      end
      S_FILL:   if (mem_ack && w_last) w_next = S_RESP;
      S_WRITE:  if (mem_ack) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; everything idles at zero.
  always_comb begin
    w_ins_ready = 1'b0;
    w_d_ready   = 1'b0;
    w_rdata     = '0;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_be    = '0;
    case (r_state)
      S_LOOKUP: begin
        if (r_op == OP_DWR) begin
          w_mem_wr    = 1'b1;
          w_mem_addr  = r_addr;
          w_mem_wdata = r_wdata;
          w_mem_be    = r_be;
        end else if (w_hit) begin
          w_ins_ready = (r_op == OP_INS);
          w_d_ready   = (r_op != OP_INS);
          w_rdata     = w_cached;
        end else begin
          w_mem_rd   = 1'b1;
          w_mem_addr = w_fill_addr;
        end
      end
      S_FILL: begin
        if (mem_ack && w_last) begin
          w_ins_ready = (r_op == OP_INS);
          w_d_ready   = (r_op != OP_INS);
          // The requested word may be the one arriving on this very ack.
          w_rdata     = (w_fill_wa == w_req_wa) ? mem_rdata : w_cached;
        end else begin
          w_mem_rd   = 1'b1;
          w_mem_addr = mem_ack ? (w_fill_addr + 32'd4) : w_fill_addr;
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          w_d_ready = 1'b1;
        end else begin
          w_mem_wr    = 1'b1;
          w_mem_addr  = r_addr;
          w_mem_wdata = r_wdata;
          w_mem_be    = r_be;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ins_ready <= 1'b0;
      r_d_ready   <= 1'b0;
      r_ins_rdata <= '0;
      r_d_rdata   <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_valid     <= '0;
      r_k         <= '0;
      r_op        <= OP_INS;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
    end else begin
      r_ins_ready <= w_ins_ready;
      r_d_ready   <= w_d_ready;
      r_ins_rdata <= w_ins_ready ? w_rdata : '0;
      r_d_rdata   <= w_d_ready ? w_rdata : '0;
      r_mem_rd    <= w_mem_rd;
      r_mem_wr    <= w_mem_wr;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_be    <= w_mem_be;
      if (r_state == S_IDLE) begin
        if (flush) begin
          r_valid <= '0;
        end else if (w_any) begin
          r_op    <= d_wr ? OP_DWR : (d_rd ? OP_DRD : OP_INS);
          r_addr  <= (d_wr || d_rd) ? d_addr : ins_addr;
          r_wdata <= d_wdata;
          r_be    <= d_be;
        end
      end
      if (r_state == S_FILL && mem_ack) begin
        r_k <= w_last ? '0 : r_k + K_W'(1);
        if (w_last) r_valid[w_index] <= 1'b1;
      end
    end
  end

  // Line storage has no reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (rst_n && r_state == S_FILL && mem_ack) begin
      r_data[w_fill_wa] <= mem_rdata;
      if (w_last) r_tag[w_index] <= w_tag;
    end
    if (rst_n && r_state == S_WRITE && mem_ack && w_hit) begin
      r_data[w_req_wa] <= w_merged;
    end
  end

  assign ins_ready = r_ins_ready;
  assign ins_rdata = r_ins_rdata;
  assign d_ready   = r_d_ready;
  assign d_rdata   = r_d_rdata;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
endmodule

// File: tb/tb_l2_cache_ctrl.sv
// tb_l2_cache_ctrl: directed transaction table against a behavioural memory that acks each word two cycles after
// the request, plus sequences for simultaneous requests, flush and reset during a fill.
module tb_l2_cache_ctrl;
  localparam int unsigned MEM_WORDS = 1024;

  typedef enum int {T_INS, T_DRD, T_DWR, T_BOTH} top_t;
  typedef struct {
    top_t        op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  logic        clk, rst_n, flush, ins_req, ins_ready, d_rd, d_wr, d_ready;
  logic        mem_rd, mem_wr, mem_ack;
  logic [31:0] ins_addr, ins_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  d_be, mem_be;

  logic [31:0] tb_mem [MEM_WORDS];
  logic [31:0] rd_log [$];
  logic [31:0] wr_log [$];
  logic [3:0]  wr_be_log [$];
  int n_chk   = 0;
  int n_pass  = 0;
  int overlap = 0;

  l2_cache_ctrl #(.INDEX_W(4), .LINE_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ins_req(ins_req), .ins_addr(ins_addr), .ins_rdata(ins_rdata), .ins_ready(ins_ready),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: one-cycle ack pulse on the edge after a request is seen, then idle for a cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem_ack   <= 1'b0;
      mem_rdata <= '0;
    end else if (mem_ack) begin
      mem_ack <= 1'b0;
    end else if (mem_rd || mem_wr) begin
      mem_ack <= 1'b1;
      if (mem_wr) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) tb_mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        wr_log.push_back(mem_addr);
        wr_be_log.push_back(mem_be);
        mem_rdata <= '0;
      end else begin
        mem_rdata <= tb_mem[mem_addr[11:2]];
        rd_log.push_back(mem_addr);
      end
    end
  end

  always @(negedge clk) if (rst_n && mem_rd && mem_wr) overlap++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int cyc;
    logic got, other, is_ins;
    logic [31:0] rdata;
    is_ins = (v.op == T_INS);
    rd_log.delete();
    wr_log.delete();
    wr_be_log.delete();
    ins_addr = v.addr;
    d_addr   = v.addr;
    d_wdata  = v.wdata;
    d_be     = v.be;
    ins_req  = is_ins;
    d_rd     = (v.op == T_DRD) || (v.op == T_BOTH);
    d_wr     = (v.op == T_DWR) || (v.op == T_BOTH);
    cyc = 0; got = 1'b0; other = 1'b0; rdata = '0;
    while (!got && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (is_ins ? ins_ready : d_ready) begin
        got = 1'b1;
        rdata = is_ins ? ins_rdata : d_rdata;
      end
      if (is_ins ? d_ready : ins_ready) other = 1'b1;
    end
    ins_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    chk($sformatf("%s_ready", tag), 32'(got), 32'd1);
    chk($sformatf("%s_other_port", tag), 32'(other), 32'd0);
    chk($sformatf("%s_rdata", tag), rdata, v.exp_rdata);
    chk($sformatf("%s_mem_reads", tag), 32'(rd_log.size()), 32'(v.exp_rd));
    chk($sformatf("%s_mem_writes", tag), 32'(wr_log.size()), 32'(v.exp_wr));
    chk($sformatf("%s_latency", tag), 32'(cyc), 32'(2 + 2 * (v.exp_rd + v.exp_wr)));
    if (v.exp_rd == 4 && rd_log.size() == 4)
      for (int k = 0; k < 4; k++)
        chk($sformatf("%s_fill_addr%0d", tag, k), rd_log[k], (v.addr & ~32'hF) + 32'(4 * k));
    if (v.exp_wr == 1 && wr_log.size() == 1) begin
      chk($sformatf("%s_wr_addr", tag), wr_log[0], v.addr);
      chk($sformatf("%s_wr_be", tag), 32'(wr_be_log[0]), 32'(v.be));
    end
    @(posedge clk); #1;
    chk($sformatf("%s_ready_pulse", tag), 32'(is_ins ? ins_ready : d_ready), 32'd0);
  endtask

  initial begin
    vec_t vecs [16];
    vec_t v;
    int cyc;
    logic got, early;
    logic [31:0] rdata;

    for (int i = 0; i < int'(MEM_WORDS); i++) tb_mem[i] = 32'h1000_0000 | 32'(i * 4);
    tb_mem[17] = 32'h1122_3344;

    vecs[0]  = '{T_INS,  32'h040, 32'h0,         4'h0, 32'h1000_0040, 4, 0};
    vecs[1]  = '{T_INS,  32'h048, 32'h0,         4'h0, 32'h1000_0048, 0, 0};
    vecs[2]  = '{T_DWR,  32'h044, 32'hAABB_CCDD, 4'h3, 32'h0,         0, 1};
    vecs[3]  = '{T_DRD,  32'h044, 32'h0,         4'h0, 32'h1122_CCDD, 0, 0};
    vecs[4]  = '{T_DWR,  32'h400, 32'hCAFE_F00D, 4'hF, 32'h0,         0, 1};
    vecs[5]  = '{T_DRD,  32'h400, 32'h0,         4'h0, 32'hCAFE_F00D, 4, 0};
    vecs[6]  = '{T_DRD,  32'h440, 32'h0,         4'h0, 32'h1000_0440, 4, 0};
    vecs[7]  = '{T_INS,  32'h040, 32'h0,         4'h0, 32'h1000_0040, 4, 0};
    vecs[8]  = '{T_INS,  32'h044, 32'h0,         4'h0, 32'h1122_CCDD, 0, 0};
    vecs[9]  = '{T_DWR,  32'h04C, 32'hDEAD_BEEF, 4'hC, 32'h0,         0, 1};
    vecs[10] = '{T_INS,  32'h04C, 32'h0,         4'h0, 32'hDEAD_004C, 0, 0};
    vecs[11] = '{T_BOTH, 32'h088, 32'h1234_5678, 4'hF, 32'h0,         0, 1};
    vecs[12] = '{T_DRD,  32'h084, 32'h0,         4'h0, 32'h1000_0084, 4, 0};
    vecs[13] = '{T_INS,  32'h088, 32'h0,         4'h0, 32'h1234_5678, 0, 0};
    vecs[14] = '{T_DWR,  32'h048, 32'h1122_3344, 4'h6, 32'h0,         0, 1};
    vecs[15] = '{T_DRD,  32'h048, 32'h0,         4'h0, 32'h1022_3348, 0, 0};

    rst_n = 1'b0; flush = 1'b0; ins_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    ins_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", 32'({ins_ready, d_ready, mem_rd, mem_wr}), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_ins_rdata", ins_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Both ports request together: data first, instruction request held and served after.
    rd_log.delete();
    ins_addr = 32'h088; d_addr = 32'h084; ins_req = 1'b1; d_rd = 1'b1;
    cyc = 0; got = 1'b0; early = 1'b0; rdata = '0;
    while (!got && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (ins_ready) early = 1'b1;
      if (d_ready) begin got = 1'b1; rdata = d_rdata; end
    end
    d_rd = 1'b0;
    chk("sim_d_ready", 32'(got), 32'd1);
    chk("sim_d_first", 32'(early), 32'd0);
    chk("sim_d_rdata", rdata, 32'h1000_0084);
    cyc = 0; got = 1'b0; rdata = '0;
    while (!got && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (ins_ready) begin got = 1'b1; rdata = ins_rdata; end
    end
    ins_req = 1'b0;
    chk("sim_i_ready", 32'(got), 32'd1);
    chk("sim_i_rdata", rdata, 32'h1234_5678);
    chk("sim_mem_reads", 32'(rd_log.size()), 32'd0);
    @(posedge clk); #1;

    v = '{T_INS, 32'h040, 32'h0, 4'h0, 32'h1000_0040, 0, 0};
    run_txn(v, "pre_flush");
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    v = '{T_INS, 32'h040, 32'h0, 4'h0, 32'h1000_0040, 4, 0};
    run_txn(v, "post_flush");

    // Reset while the second word of a fill is outstanding.
    rd_log.delete();
    ins_addr = 32'h0C0; ins_req = 1'b1;
    cyc = 0;
    while (!(rd_log.size() == 1 && mem_rd && !mem_ack) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rmf_second_addr", mem_addr, 32'h0C4);
    rst_n = 1'b0; ins_req = 1'b0;
    @(posedge clk); #1;
    chk("rmf_mem_rd_drop", 32'(mem_rd), 32'd0);
    chk("rmf_no_ready", 32'(ins_ready), 32'd0);
    rst_n = 1'b1;
    early = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ins_ready || d_ready || mem_rd) early = 1'b1;
    end
    chk("rmf_quiet", 32'(early), 32'd0);
    v = '{T_INS, 32'h0C0, 32'h0, 4'h0, 32'h1000_00C0, 4, 0};
    run_txn(v, "rmf_refill");

    chk("rd_wr_overlap", 32'(overlap), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
